hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_match.sv | 12 +
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths, forwarding-select and FSM encodings, shadow entry layout.
package hazard_ctrl_pkg;
    localparam int REG_W = 3;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWB = 2'd2} fwd_sel_t;
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1} state_t;
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             is_load;
    } shadow_t;
    function automatic fwd_sel_t pick_fwd(input logic ex_hit, input logic mem_hit);
        return ex_hit ? FWD_EXMEM : (mem_hit ? FWD_MEMWB : FWD_RF);
    endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one source register against one shadow producer; r0 never matches.
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] dest,
    input  logic             wb_en,
    output logic             match
);
    assign match = use_src & wb_en & (src == dest) & (dest != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble/flush control with stall counter.
// Define HAZARD_FORWARD_EN to enable EX/MEM forwarding (only load-use stalls remain).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_is_load,
    input  logic             branch_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);
    shadow_t ex_q, mem_q;
    state_t  state_q, state_d;
    logic    m1e, m1m, m2e, m2m, hazard, issue;
    logic    unused;

    hazard_match u_m1e (.src(id_src1), .use_src(id_use_src1), .dest(ex_q.dest),  .wb_en(ex_q.wb_en),  .match(m1e));
    hazard_match u_m1m (.src(id_src1), .use_src(id_use_src1), .dest(mem_q.dest), .wb_en(mem_q.wb_en), .match(m1m));
    hazard_match u_m2e (.src(id_src2), .use_src(id_use_src2), .dest(ex_q.dest),  .wb_en(ex_q.wb_en),  .match(m2e));
    hazard_match u_m2m (.src(id_src2), .use_src(id_use_src2), .dest(mem_q.dest), .wb_en(mem_q.wb_en), .match(m2m));

`ifdef HAZARD_FORWARD_EN
    assign hazard = id_valid & (m1e | m2e) & ex_q.is_load;
`else
    assign hazard = id_valid & (m1e | m1m | m2e | m2m);
`endif

    assign issue  = id_valid & ~stall & ~bubble;
    assign state  = state_q;
    assign unused = mem_q.is_load;

    // Branch squash outranks a hazard; outputs are forced low while reset is held.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        if (!rst) begin
            if (state_q == FLUSH) begin
                flush   = 1'b1;
                bubble  = 1'b1;
                state_d = RUN;
            end else if (branch_taken) begin
                flush   = 1'b1;
                bubble  = 1'b1;
                state_d = FLUSH;
            end else if (hazard) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            state_q   <= RUN;
            stall_cnt <= '0;
        end else begin
            ex_q    <= issue ? '{dest: id_dest, wb_en: id_wb_en, is_load: id_is_load} : '0;
            mem_q   <= ex_q;
            state_q <= state_d;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

`ifdef HAZARD_FORWARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel1 <= FWD_RF;
            fwd_sel2 <= FWD_RF;
        end else begin
            fwd_sel1 <= issue ? pick_fwd(m1e, m1m) : FWD_RF;
            fwd_sel2 <= issue ? pick_fwd(m2e, m2m) : FWD_RF;
        end
    end
`else
    assign fwd_sel1 = FWD_RF;
    assign fwd_sel2 = FWD_RF;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios for hazard_ctrl, with expectations for either build.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_use_src1 = 1'b0, id_use_src2 = 1'b0;
    logic [2:0]  id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic        id_wb_en = 1'b0, id_is_load = 1'b0, branch_taken = 1'b0;
    logic        stall, bubble, flush;
    logic [1:0]  fwd_sel1, fwd_sel2, state;
    logic [15:0] stall_cnt;
    int          tests = 0;
    int          fails = 0;
    int          exp_cnt = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_is_load(id_is_load), .branch_taken(branch_taken),
        .stall(stall), .bubble(bubble), .flush(flush), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed 1 time unit later.
    task automatic drive(input logic v, input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                         input logic u2, input logic [2:0] d, input logic wb, input logic ld,
                         input logic br);
        @(negedge clk);
        id_valid = v; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
        id_dest = d; id_wb_en = wb; id_is_load = ld; branch_taken = br;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0; id_use_src1 = 1'b0; id_use_src2 = 1'b0; id_wb_en = 1'b0;
        id_is_load = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 3'd1, 1, 3'd2, 1, 3'd1, 1, 1, 1);
        if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tests++;
        if (bubble !== 1'b0) begin fails++; $display("FAIL reset_bubble got=%b exp=0", bubble); end
        tests++;
        if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got=%b exp=0", flush); end
        tests++;
        if (state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
        tests++;
        if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin
            fails++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_sel1, fwd_sel2);
        end
        tests++;
        if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        tests++;
        do_reset();
    endtask

`ifdef HAZARD_FORWARD_EN
    task automatic test_forward();
        do_reset();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0);
        drive(1, 3'd1, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL fwd_add_stall got=%b exp=0", stall); end
        tests++;
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        if (fwd_sel1 !== 2'd1 || fwd_sel2 !== 2'd0) begin
            fails++; $display("FAIL fwd_add_sel got=%0d/%0d exp=1/0", fwd_sel1, fwd_sel2);
        end
        tests++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0);
        drive(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0);
        if (stall !== 1'b1 || bubble !== 1'b1) begin
            fails++; $display("FAIL lu_stall got=%b/%b exp=1/1", stall, bubble);
        end
        tests++;
        drive(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL lu_release got=%b exp=0", stall); end
        tests++;
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        if (fwd_sel2 !== 2'd2 || fwd_sel1 !== 2'd0) begin
            fails++; $display("FAIL lu_sel got=%0d/%0d exp=0/2", fwd_sel1, fwd_sel2);
        end
        tests++;
        if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        tests++;
    endtask
`else
    task automatic test_no_forward();
        do_reset();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL nf_prod_stall got=%b exp=0", stall); end
        tests++;
        drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall !== 1'b1 || bubble !== 1'b1 || flush !== 1'b0) begin
            fails++; $display("FAIL nf_stall1 got=%b%b%b exp=110", stall, bubble, flush);
        end
        tests++;
        drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall !== 1'b1) begin fails++; $display("FAIL nf_stall2 got=%b exp=1", stall); end
        tests++;
        drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            fails++; $display("FAIL nf_release got=%b/%b exp=0/0", stall, bubble);
        end
        tests++;
        if (stall_cnt !== 16'd2) begin fails++; $display("FAIL nf_cnt got=%0d exp=2", stall_cnt); end
        tests++;
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        if (fwd_sel1 !== 2'd0) begin fails++; $display("FAIL nf_sel got=%0d exp=0", fwd_sel1); end
        tests++;
    endtask
`endif

    task automatic test_r0();
        do_reset();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0);
        drive(1, 3'd0, 1, 3'd0, 1, 3'd0, 1, 0, 0);
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            fails++; $display("FAIL r0_ex got=%b/%b exp=0/0", stall, bubble);
        end
        tests++;
        drive(1, 3'd0, 1, 3'd0, 1, 3'd0, 0, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL r0_mem got=%b exp=0", stall); end
        tests++;
        if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin
            fails++; $display("FAIL r0_sel got=%0d/%0d exp=0/0", fwd_sel1, fwd_sel2);
        end
        tests++;
    endtask

    task automatic test_unused_src();
        do_reset();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1, 0);
        drive(1, 3'd4, 0, 3'd4, 0, 3'd5, 0, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL unused_src got=%b exp=0", stall); end
        tests++;
        drive(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL no_wb got=%b exp=0", stall); end
        tests++;
    endtask

    task automatic test_branch_hazard();
        do_reset();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0);
        drive(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 1);
        if (flush !== 1'b1 || bubble !== 1'b1 || stall !== 1'b0 || state !== 2'd0) begin
            fails++; $display("FAIL br_cyc1 fbs=%b%b%b st=%0d exp=110 st=0", flush, bubble, stall, state);
        end
        tests++;
        drive(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 1);
        if (flush !== 1'b1 || bubble !== 1'b1 || stall !== 1'b0 || state !== 2'd1) begin
            fails++; $display("FAIL br_cyc2 fbs=%b%b%b st=%0d exp=110 st=1", flush, bubble, stall, state);
        end
        tests++;
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        if (flush !== 1'b0 || bubble !== 1'b0 || state !== 2'd0) begin
            fails++; $display("FAIL br_cyc3 fb=%b%b st=%0d exp=00 st=0", flush, bubble, state);
        end
        tests++;
        if (stall_cnt !== 16'd0) begin fails++; $display("FAIL br_cnt got=%0d exp=0", stall_cnt); end
        tests++;
    endtask

    // Producer r3 then consumer after gap unrelated instructions; expected stalls derived per build.
    task automatic stall_pair(input int gap);
        int es;
`ifdef HAZARD_FORWARD_EN
        es = (gap == 0) ? 1 : 0;
`else
        es = (gap >= 2) ? 0 : 2 - gap;
`endif
        drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
        for (int g = 0; g < gap; g++) drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        for (int k = 0; k < es; k++) begin
            drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
            if (stall !== 1'b1) begin fails++; $display("FAIL pair_stall k=%0d got=%b exp=1", k, stall); end
            tests++;
        end
        drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall !== 1'b0) begin fails++; $display("FAIL pair_release got=%b exp=0", stall); end
        tests++;
        exp_cnt += es;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
`ifdef HAZARD_FORWARD_EN
        for (int p = 0; p < 5; p++) stall_pair(0);
`else
        stall_pair(0);
        stall_pair(0);
        stall_pair(1);
`endif
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        if (stall_cnt !== 16'(exp_cnt) || exp_cnt != 5) begin
            fails++; $display("FAIL pre_cnt got=%0d exp=5 model=%0d", stall_cnt, exp_cnt);
        end
        tests++;
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        if (state !== 2'd1) begin fails++; $display("FAIL mid_flush_state got=%0d exp=1", state); end
        tests++;
        rst = 1'b1;
        #1;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            fails++; $display("FAIL rst_flush st=%0d cnt=%0d exp=0/0", state, stall_cnt);
        end
        tests++;
        if (stall !== 1'b0 || bubble !== 1'b0 || flush !== 1'b0) begin
            fails++; $display("FAIL rst_flush_out sbf=%b%b%b exp=000", stall, bubble, flush);
        end
        tests++;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 3'd3, 1, 3'd3, 1, 3'd0, 0, 0, 0);
        if (state !== 2'd0 || stall !== 1'b0 || flush !== 1'b0) begin
            fails++; $display("FAIL post_rst st=%0d s=%b f=%b exp=0/0/0", state, stall, flush);
        end
        tests++;
    endtask

    initial begin
        test_reset();
`ifdef HAZARD_FORWARD_EN
        test_forward();
        test_load_use();
`else
        test_no_forward();
`endif
        test_r0();
        test_unused_src();
        test_branch_hazard();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
